// File: rtl/vga_buf_pkg.sv
// Shared types and sizing helpers for the ping-pong frame buffer.
// AW is the address width for the default 160-entry configuration.
package vga_buf_pkg;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  localparam int DEPTH_DEFAULT = 160;
  localparam int AW = addr_w(DEPTH_DEFAULT);

endpackage

// File: rtl/vga_dp_bank.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// The read register is reset and holds its value when re is low.
module vga_dp_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 160,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Storage is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vga_frame_buffer_pingpong.sv
// Ping-pong frame buffer: writer fills the back bank and commits, the swap
// happens on the reader's next frame_start. Read latency is one cycle.
//
// Handshake: a write or commit is taken on a rising edge only when wr_ready
// is high; wr_en while wr_ready is low (or out of range) is dropped and
// counted, wr_commit while wr_ready is low is ignored.
module vga_frame_buffer_pingpong
  import vga_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 160,
  parameter int DROP_W = 8,
  parameter int AW     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              frame_start,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              swap_pulse,
  output logic              frame_repeat,
  output logic              front_sel,
  output logic [DROP_W-1:0] drop_count,
  output state_e            state_dbg
);

  state_e            state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic              wr_ready_q, wr_ready_d;
  logic              swap_pulse_q, swap_pulse_d;
  logic              frame_repeat_q, frame_repeat_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_oor_q, rd_oor_d;
  logic              rd_sel_q, rd_sel_d;

  logic              wr_in_range, rd_in_range;
  logic              wr_accept, wr_drop;
  logic              rd_fetch;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  assign wr_in_range = 32'(wr_addr) < DEPTH;
  assign rd_in_range = 32'(rd_addr) < DEPTH;
  assign wr_accept   = wr_en && (state_q == FILL) && wr_in_range;
  assign wr_drop     = wr_en && !((state_q == FILL) && wr_in_range);
  assign rd_fetch    = rd_en && rd_in_range;

  always_comb begin
    state_d        = state_q;
    front_sel_d    = front_sel_q;
    swap_pulse_d   = 1'b0;
    frame_repeat_d = 1'b0;
    drop_count_d   = drop_count_q;

    case (state_q)
      FILL: begin
        // Nothing committed yet: the reader re-displays the current front.
        if (frame_start) frame_repeat_d = 1'b1;
        if (wr_commit)   state_d = PENDING;
      end
      PENDING: begin
        if (frame_start) begin
          front_sel_d  = ~front_sel_q;
          swap_pulse_d = 1'b1;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (wr_drop && (drop_count_q != {DROP_W{1'b1}}))
      drop_count_d = drop_count_q + 1'b1;

    wr_ready_d = (state_d == FILL);

    rd_valid_d = rd_en;
    rd_oor_d   = rd_en ? !rd_in_range : rd_oor_q;
    rd_sel_d   = rd_en ? front_sel_q  : rd_sel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FILL;
      front_sel_q    <= 1'b0;
      wr_ready_q     <= 1'b1;
      swap_pulse_q   <= 1'b0;
      frame_repeat_q <= 1'b0;
      drop_count_q   <= '0;
      rd_valid_q     <= 1'b0;
      rd_oor_q       <= 1'b0;
      rd_sel_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      front_sel_q    <= front_sel_d;
      wr_ready_q     <= wr_ready_d;
      swap_pulse_q   <= swap_pulse_d;
      frame_repeat_q <= frame_repeat_d;
      drop_count_q   <= drop_count_d;
      rd_valid_q     <= rd_valid_d;
      rd_oor_q       <= rd_oor_d;
      rd_sel_q       <= rd_sel_d;
    end
  end

  vga_dp_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank_a (
    .clk   (clk),
    .reset (reset),
    .we    (wr_accept && front_sel_q),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_fetch && !front_sel_q),
    .raddr (rd_addr),
    .rdata (rdata_a)
  );

  vga_dp_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank_b (
    .clk   (clk),
    .reset (reset),
    .we    (wr_accept && !front_sel_q),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_fetch && front_sel_q),
    .raddr (rd_addr),
    .rdata (rdata_b)
  );

  // Bank selected at issue time, so a read in the swap cycle sees the old front.
  assign rd_data      = rd_oor_q ? '0 : (rd_sel_q ? rdata_b : rdata_a);
  assign rd_valid     = rd_valid_q;
  assign wr_ready     = wr_ready_q;
  assign swap_pulse   = swap_pulse_q;
  assign frame_repeat = frame_repeat_q;
  assign front_sel    = front_sel_q;
  assign drop_count   = drop_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_vga_frame_buffer_pingpong.sv
// Directed bench for the ping-pong frame buffer (DATA_W=8, DEPTH=160, DROP_W=8).
module tb_vga_frame_buffer_pingpong;
  import vga_buf_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 160;
  localparam int DROP_W = 8;
  localparam int TAW    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [TAW-1:0]    wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_commit;
  logic              wr_ready;
  logic              frame_start;
  logic              rd_en;
  logic [TAW-1:0]    rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              swap_pulse;
  logic              frame_repeat;
  logic              front_sel;
  logic [DROP_W-1:0] drop_count;
  state_e            state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  vga_frame_buffer_pingpong #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_commit    (wr_commit),
    .wr_ready     (wr_ready),
    .frame_start  (frame_start),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .swap_pulse   (swap_pulse),
    .frame_repeat (frame_repeat),
    .front_sel    (front_sel),
    .drop_count   (drop_count),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_commit = 0;
    frame_start = 0; rd_en = 0; rd_addr = '0;
  endtask

  task automatic do_write(input int addr, input int data);
    wr_en = 1; wr_addr = TAW'(addr); wr_data = DATA_W'(data);
    step();
    wr_en = 0;
  endtask

  task automatic do_read(input int addr);
    rd_en = 1; rd_addr = TAW'(addr);
    step();
    rd_en = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;

    check("rst_front_sel", 32'(front_sel), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_state", 32'(state_dbg), 32'(FILL));
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_swap", 32'(swap_pulse), 0);
    check("rst_repeat", 32'(frame_repeat), 0);
    check("rst_drop", 32'(drop_count), 0);

    // Fill back bank B with data = addr, then commit.
    for (int i = 0; i < DEPTH; i++) do_write(i, i);
    wr_commit = 1; step(); wr_commit = 0;
    check("commit_wr_ready", 32'(wr_ready), 0);
    check("commit_state", 32'(state_dbg), 32'(PENDING));

    // Write while pending is dropped.
    do_write(3, 8'hAA);
    check("pend_drop", 32'(drop_count), 1);
    check("pend_wr_ready", 32'(wr_ready), 0);

    frame_start = 1; step(); frame_start = 0;
    check("swap1_pulse", 32'(swap_pulse), 1);
    check("swap1_front", 32'(front_sel), 1);
    check("swap1_wr_ready", 32'(wr_ready), 1);
    step();
    check("swap1_pulse_end", 32'(swap_pulse), 0);

    do_read(5);
    check("rd5_data", 32'(rd_data), 5);
    check("rd5_valid", 32'(rd_valid), 1);
    step();
    check("rd_idle_valid", 32'(rd_valid), 0);
    check("rd_idle_hold", 32'(rd_data), 5);
    do_read(3);
    check("rd3_old_value", 32'(rd_data), 3);

    // frame_start with nothing committed.
    frame_start = 1; step(); frame_start = 0;
    check("rep_pulse", 32'(frame_repeat), 1);
    check("rep_front", 32'(front_sel), 1);
    check("rep_swap", 32'(swap_pulse), 0);
    step();
    check("rep_pulse_end", 32'(frame_repeat), 0);

    // Bank A is back: write, commit and frame_start all in one cycle.
    wr_en = 1; wr_addr = 10; wr_data = 8'h55; wr_commit = 1; frame_start = 1;
    step();
    idle_inputs();
    check("cf_repeat", 32'(frame_repeat), 1);
    check("cf_swap", 32'(swap_pulse), 0);
    check("cf_front", 32'(front_sel), 1);
    check("cf_wr_ready", 32'(wr_ready), 0);
    check("cf_drop", 32'(drop_count), 1);

    // Read in the swap cycle sees old front (B), next cycle new front (A).
    frame_start = 1; rd_en = 1; rd_addr = 10;
    step();
    frame_start = 0;
    check("sw2_pulse", 32'(swap_pulse), 1);
    check("sw2_front", 32'(front_sel), 0);
    check("sw2_rd_old", 32'(rd_data), 10);
    check("sw2_rd_valid", 32'(rd_valid), 1);
    step();
    rd_en = 0;
    check("sw2_rd_new", 32'(rd_data), 8'h55);

    do_write(200, 8'h77);
    check("oor_wr_drop", 32'(drop_count), 2);
    do_read(200);
    check("oor_rd_data", 32'(rd_data), 0);
    check("oor_rd_valid", 32'(rd_valid), 1);

    // Reach PENDING with front_sel = 1, then reset with a read in flight.
    wr_commit = 1; step(); wr_commit = 0;
    frame_start = 1; step(); frame_start = 0;
    wr_commit = 1; step(); wr_commit = 0;
    check("pre_rst_front", 32'(front_sel), 1);
    check("pre_rst_state", 32'(state_dbg), 32'(PENDING));
    reset = 1; rd_en = 1; rd_addr = 5;
    step();
    reset = 0; rd_en = 0;
    check("mid_rst_front", 32'(front_sel), 0);
    check("mid_rst_wr_ready", 32'(wr_ready), 1);
    check("mid_rst_drop", 32'(drop_count), 0);
    check("mid_rst_rd_valid", 32'(rd_valid), 0);
    check("mid_rst_state", 32'(state_dbg), 32'(FILL));

    // Saturation of the drop counter.
    for (int i = 0; i < 254; i++) do_write(200 + (i % 56), 0);
    check("drop_254", 32'(drop_count), 254);
    for (int i = 0; i < 46; i++) do_write(200, 0);
    check("drop_sat", 32'(drop_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
